// File: rtl/pdm_capture.sv
// Stereo PDM front end: samples left on mic_clk rises and right on falls, boxcar-decimates
// DECIM bits per channel, and hands out (left, right) pairs on a valid/ready interface.
module pdm_capture #(
  parameter int DECIM = 64,
  parameter int OUT_W = $clog2(DECIM) + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             mic_clk,
  input  logic             pdm_data,
  output logic [OUT_W-1:0] sample_l,
  output logic [OUT_W-1:0] sample_r,
  output logic             sample_valid,
  input  logic             sample_ready,
  output logic             overrun
);

  localparam int BW = $clog2(DECIM);
  localparam logic [BW-1:0] LAST = BW'(DECIM - 1);

  logic             mic_q, pdm_m, pdm_s, started;
  logic             rise, fall, frame_done, load;
  logic [OUT_W-1:0] acc_l, acc_r, bit_w;
  logic [BW-1:0]    bcnt;

  // mic_clk is already registered by the divider in this domain; only the data needs syncing
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      mic_q <= 1'b0;
      pdm_m <= 1'b0;
      pdm_s <= 1'b0;
    end else begin
      mic_q <= mic_clk;
      pdm_m <= pdm_data;
      pdm_s <= pdm_m;
    end
  end

  always_comb begin
    rise       = mic_clk & ~mic_q;
    fall       = ~mic_clk & mic_q;
    bit_w      = OUT_W'(pdm_s);
    frame_done = en & started & fall & (bcnt == LAST);
    load       = frame_done & (~sample_valid | sample_ready);
  end

  // Alignment always restarts on a rise, so falls are ignored until the first rise is seen
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      acc_l   <= '0;
      acc_r   <= '0;
      bcnt    <= '0;
      started <= 1'b0;
    end else if (!en) begin
      acc_l   <= '0;
      acc_r   <= '0;
      bcnt    <= '0;
      started <= 1'b0;
    end else if (!started) begin
      if (rise) begin
        started <= 1'b1;
        acc_l   <= bit_w;
      end
    end else if (rise) begin
      acc_l <= acc_l + bit_w;
    end else if (fall) begin
      if (bcnt == LAST) begin
        acc_l <= '0;
        acc_r <= '0;
        bcnt  <= '0;
      end else begin
        acc_r <= acc_r + bit_w;
        bcnt  <= bcnt + BW'(1);
      end
    end
  end

  // A completed frame that cannot be stored is dropped; the pending pair is never overwritten
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sample_l     <= '0;
      sample_r     <= '0;
      sample_valid <= 1'b0;
      overrun      <= 1'b0;
    end else begin
      overrun <= 1'b0;
      if (frame_done) begin
        if (load) begin
          sample_l     <= acc_l;
          sample_r     <= acc_r + bit_w;
          sample_valid <= 1'b1;
        end else begin
          overrun <= 1'b1;
        end
      end else if (sample_ready) begin
        sample_valid <= 1'b0;
      end
    end
  end

endmodule
